// File: rtl/uart_pkg.sv
// Shared constants for the FIFO-draining UART transmitter: state encoding,
// data width and the idle level of the serial line.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam logic UART_IDLE = 1'b1;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t IDLE  = 3'd0;
    localparam uart_state_t POP   = 3'd1;
    localparam uart_state_t WAIT  = 3'd2;
    localparam uart_state_t START = 3'd3;
    localparam uart_state_t DATA  = 3'd4;
    localparam uart_state_t STOP  = 3'd5;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// bit_tick_nxt is what bit_tick will be next cycle, so the owner can register outputs.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick,
    output logic bit_tick_nxt
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (clear || (r_cnt == LAST)) begin
            w_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign bit_tick     = (r_cnt == LAST);
    assign bit_tick_nxt = (w_cnt_nxt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO one pop at a time and sends each byte as an 8N1/8N2 UART frame.
// Every output is a flop loaded from the next-state/next-datapath values.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_en,
    input  logic                   fifo_empty,
    input  logic [UART_DATA_W-1:0] fifo_dout,
    output logic                   fifo_rd_en,
    output logic                   tx,
    output logic                   busy,
    output logic                   frame_done
);

    localparam logic [2:0] LAST_DATA_IDX = 3'd7;
    localparam logic [2:0] LAST_STOP_IDX = 3'(STOP_BITS - 1);

    uart_state_t            r_state;
    uart_state_t            w_state_nxt;
    logic [2:0]             r_bit_idx;
    logic [2:0]             w_bit_idx_nxt;
    logic [UART_DATA_W-1:0] r_shift;
    logic [UART_DATA_W-1:0] w_shift_nxt;

    logic r_tx;
    logic r_rd_en;
    logic r_busy;
    logic r_frame_done;
    logic w_tx_nxt;
    logic w_rd_en_nxt;
    logic w_busy_nxt;
    logic w_frame_done_nxt;

    logic w_bit_tick;
    logic w_bit_tick_nxt;
    logic w_baud_clear;

    // The counter sits at 0 outside the timed states and restarts on every state change.
    assign w_baud_clear = (r_state inside {IDLE, POP, WAIT}) || (w_state_nxt != r_state);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk         (clk),
        .rst         (rst),
        .clear       (w_baud_clear),
        .bit_tick    (w_bit_tick),
        .bit_tick_nxt(w_bit_tick_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (tx_en && !fifo_empty) w_state_nxt = POP;
            POP:     w_state_nxt = WAIT;
            WAIT:    w_state_nxt = START;
            START:   if (w_bit_tick) w_state_nxt = DATA;
            DATA:    if (w_bit_tick && (r_bit_idx == LAST_DATA_IDX)) w_state_nxt = STOP;
            STOP:    if (w_bit_tick && (r_bit_idx == LAST_STOP_IDX)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Bit index counts data bits in DATA and stop bits in STOP.
    always_comb begin
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        case (r_state)
            WAIT: begin
                w_shift_nxt   = fifo_dout;
                w_bit_idx_nxt = '0;
            end
            DATA: begin
                if (w_bit_tick) begin
                    w_shift_nxt   = r_shift >> 1;
                    w_bit_idx_nxt = (r_bit_idx == LAST_DATA_IDX) ? 3'd0 : r_bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (w_bit_tick) begin
                    w_bit_idx_nxt = (r_bit_idx == LAST_STOP_IDX) ? 3'd0 : r_bit_idx + 3'd1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
        end else begin
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
        end
    end

    always_comb begin
        w_rd_en_nxt      = (w_state_nxt == POP);
        w_busy_nxt       = (w_state_nxt != IDLE);
        w_tx_nxt         = UART_IDLE;
        w_frame_done_nxt = 1'b0;
        case (w_state_nxt)
            START: w_tx_nxt = ~UART_IDLE;
            DATA:  w_tx_nxt = w_shift_nxt[0];
            STOP:  w_frame_done_nxt = w_bit_tick_nxt && (w_bit_idx_nxt == LAST_STOP_IDX);
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx         <= UART_IDLE;
            r_rd_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_tx         <= w_tx_nxt;
            r_rd_en      <= w_rd_en_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign tx         = r_tx;
    assign fifo_rd_en = r_rd_en;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a FIFO environment, a frame-schedule reference model,
// table-driven single frames, hand-written corner sequences and random traffic.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int CPB   = 4;
    localparam int SB    = 1;
    localparam int FRAME = (9 + SB) * CPB;
    localparam int CPB2  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en, fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd_en, tx, busy, frame_done;
    logic       tx_en2, fifo_empty2;
    logic [7:0] fifo_dout2;
    logic       fifo_rd_en2, tx2, busy2, frame_done2;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .frame_done(frame_done)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB2), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .tx_en(tx_en2), .fifo_empty(fifo_empty2), .fifo_dout(fifo_dout2),
        .fifo_rd_en(fifo_rd_en2), .tx(tx2), .busy(busy2), .frame_done(frame_done2)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] model_q[$];
    int         m_phase = -1;
    logic [7:0] m_byte  = 8'h00;

    logic cap_on = 1'b0;
    logic cap_tx[$];
    logic cap_rd[$];
    logic cap_busy[$];
    logic cap_fd[$];
    int   a_rd, a_fd, a_busy, a_first_rd, a_first_low, a_first_fd;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        int         busy_len;
    } vec_t;
    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        model_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    // Phase p: -1 idle, 0 pop, 1 wait, 2.. frame cycles; line level from bit arithmetic.
    function automatic logic [3:0] model_out(input int p, input logic [7:0] b);
        int         q;
        logic       t;
        logic [2:0] bi;
        q = p - 2;
        t = 1'b1;
        if (p >= 2) begin
            if (q < CPB) begin
                t = 1'b0;
            end else if (q < 9 * CPB) begin
                bi = 3'((q - CPB) / CPB);
                t  = b[bi];
            end
        end
        return {p == 0, p >= 0, t, q == FRAME - 1};
    endfunction

    task automatic tick();
        logic       rd_seen, ten, emp, rs;
        logic [3:0] got, want;
        rd_seen = fifo_rd_en;
        ten     = tx_en;
        emp     = fifo_empty;
        rs      = rst;
        @(posedge clk);
        #1;
        if (rd_seen && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
        if (rs) begin
            m_phase = -1;
        end else if (m_phase < 0) begin
            if (ten && !emp) m_phase = 0;
        end else begin
            if (m_phase == 0) begin
                if (model_q.size() > 0) m_byte = model_q.pop_front();
                else m_byte = 8'h00;
            end
            m_phase = (m_phase == FRAME + 1) ? -1 : m_phase + 1;
        end
        want = model_out(m_phase, m_byte);
        got  = {fifo_rd_en, busy, tx, frame_done};
        check("cycle{rd,busy,tx,done}", 32'(got), 32'(want));
        if (cap_on) begin
            cap_tx.push_back(tx);
            cap_rd.push_back(fifo_rd_en);
            cap_busy.push_back(busy);
            cap_fd.push_back(frame_done);
        end
    endtask

    task automatic cap_start();
        cap_tx.delete();
        cap_rd.delete();
        cap_busy.delete();
        cap_fd.delete();
        cap_on = 1'b1;
    endtask

    task automatic analyse();
        a_rd = 0; a_fd = 0; a_busy = 0;
        a_first_rd = -1; a_first_low = -1; a_first_fd = -1;
        for (int i = 0; i < cap_tx.size(); i++) begin
            if (cap_rd[i]) begin
                a_rd++;
                if (a_first_rd < 0) a_first_rd = i;
            end
            if (cap_fd[i]) begin
                a_fd++;
                if (a_first_fd < 0) a_first_fd = i;
            end
            if (cap_busy[i]) a_busy++;
            if (!cap_tx[i] && a_first_low < 0) a_first_low = i;
        end
    endtask

    function automatic int next_low(input int from);
        for (int i = from; i < cap_tx.size(); i++) if (!cap_tx[i]) return i;
        return -1;
    endfunction

    function automatic int next_fd(input int from);
        for (int i = from; i < cap_fd.size(); i++) if (cap_fd[i]) return i;
        return -1;
    endfunction

    function automatic int low_run(input int from);
        int n;
        n = 0;
        for (int i = from; i >= 0 && i < cap_tx.size(); i++) begin
            if (cap_tx[i]) break;
            n++;
        end
        return n;
    endfunction

    task automatic check_frame(input string name, input logic [9:0] exp);
        logic [9:0] seen;
        int         idx;
        seen = '0;
        for (int k = 0; k < 10; k++) begin
            idx = a_first_low + k * CPB + CPB / 2;
            if (a_first_low >= 0 && idx < cap_tx.size()) seen = seen | (10'(cap_tx[idx]) << k);
        end
        check(name, 32'(seen), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] exp2;
        int          f, l, stop_high, first_low2, fd_at2;

        rst = 1'b1; tx_en = 1'b0; fifo_empty = 1'b1; fifo_dout = 8'h00;
        tx_en2 = 1'b0; fifo_empty2 = 1'b1; fifo_dout2 = 8'h80;

        vecs[0] = '{8'hA5, 10'b1101001010, 42};
        vecs[1] = '{8'h5A, 10'b1010110100, 42};
        vecs[2] = '{8'h80, 10'b1100000000, 42};

        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", 32'({fifo_rd_en, busy, tx, frame_done}), 32'(4'b0010));
        check("reset outputs dut2", 32'({fifo_rd_en2, busy2, tx2, frame_done2}), 32'(4'b0010));
        rst   = 1'b0;
        tx_en = 1'b1;

        cap_start();
        repeat (100) tick();
        cap_on = 1'b0;
        analyse();
        check("idle pops", a_rd, 0);
        check("idle busy cycles", a_busy, 0);
        check("idle first low", a_first_low, -1);

        for (int i = 0; i < 3; i++) begin
            push(vecs[i].data);
            cap_start();
            repeat (50) tick();
            cap_on = 1'b0;
            analyse();
            check($sformatf("vec%0d pops", i), a_rd, 1);
            check($sformatf("vec%0d busy len", i), a_busy, vecs[i].busy_len);
            check($sformatf("vec%0d done pulses", i), a_fd, 1);
            check($sformatf("vec%0d pop to start", i), a_first_low - a_first_rd, 2);
            check($sformatf("vec%0d done position", i), a_first_fd - a_first_low, FRAME - 1);
            check_frame($sformatf("vec%0d frame bits", i), vecs[i].frame);
        end

        push(8'h01); push(8'hFF); push(8'h00);
        cap_start();
        repeat (140) tick();
        cap_on = 1'b0;
        analyse();
        check("b2b pops", a_rd, 3);
        check("b2b done pulses", a_fd, 3);
        check("b2b busy cycles", a_busy, 3 * (FRAME + 2));
        check_frame("b2b first frame bits", 10'b1000000010);
        f = a_first_fd;
        for (int j = 0; j < 2; j++) begin
            l = (f >= 0) ? next_low(f + 1) : -1;
            check($sformatf("b2b gap%0d", j), l - f - 1, 3);
            f = (f >= 0) ? next_fd(f + 1) : -1;
        end

        push(8'h3C); push(8'h11);
        cap_start();
        repeat (12) tick();
        tx_en = 1'b0;
        repeat (60) tick();
        cap_on = 1'b0;
        analyse();
        check("txen drop pops", a_rd, 1);
        check("txen drop done pulses", a_fd, 1);
        check("txen drop busy at end", 32'(cap_busy[cap_busy.size() - 1]), 0);
        check("txen drop bytes left", fifo_q.size(), 1);
        check_frame("txen drop frame bits", 10'b1001111000);
        fifo_q.delete(); model_q.delete(); fifo_empty = 1'b1; tx_en = 1'b1;

        push(8'h9C);
        tick();
        check("pop strobe before reset", 32'(fifo_rd_en), 1);
        #2 rst = 1'b1;
        #1 check("reset in POP", 32'({fifo_rd_en, busy, tx, frame_done}), 32'(4'b0010));
        tick(); tick();
        rst = 1'b0;
        cap_start();
        repeat (50) tick();
        cap_on = 1'b0;
        analyse();
        check("after POP reset pops", a_rd, 1);
        check("after POP reset done pulses", a_fd, 1);
        check_frame("after POP reset frame bits", 10'b1100111000);

        push(8'h55); push(8'h67);
        repeat (20) tick();
        check("in DATA before reset", 32'(busy), 1);
        #2 rst = 1'b1;
        #1 check("reset in DATA", 32'({fifo_rd_en, busy, tx, frame_done}), 32'(4'b0010));
        tick(); tick();
        rst = 1'b0;
        cap_start();
        repeat (50) tick();
        cap_on = 1'b0;
        analyse();
        check("after DATA reset pops", a_rd, 1);
        check("after DATA reset first pop", a_first_rd, 0);
        check("after DATA reset start bit", low_run(a_first_low), CPB);
        check_frame("after DATA reset frame bits", 10'b1011001110);
        check("after DATA reset bytes left", fifo_q.size(), 0);

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0 && fifo_q.size() < 16) push(8'($urandom));
            if ($urandom_range(0, 59) == 0) tx_en = ~tx_en;
            tick();
        end
        tx_en = 1'b1;
        for (int c = 0; c < 2000 && (fifo_q.size() > 0 || m_phase >= 0); c++) tick();
        check("random drain bytes left", fifo_q.size(), 0);
        check("random drain busy", 32'(busy), 0);

        exp2 = 11'b11100000000;
        stop_high = 0; first_low2 = -1; fd_at2 = -1;
        tx_en2 = 1'b1; fifo_empty2 = 1'b0;
        @(posedge clk); #1;
        check("dut2 pop strobe", 32'(fifo_rd_en2), 1);
        fifo_empty2 = 1'b1;
        @(posedge clk); #1;
        check("dut2 wait cycle", 32'({fifo_rd_en2, busy2, tx2}), 32'(3'b011));
        for (int k = 0; k < 33; k++) begin
            @(posedge clk); #1;
            check($sformatf("dut2 cycle%0d", k), 32'({busy2, tx2, frame_done2}),
                  32'({1'b1, exp2[k / CPB2], k == 32}));
            if (!tx2 && first_low2 < 0) first_low2 = k;
            if (frame_done2 && fd_at2 < 0) fd_at2 = k;
            if (k >= 27 && tx2) stop_high++;
        end
        @(posedge clk); #1;
        check("dut2 after frame", 32'({fifo_rd_en2, busy2, frame_done2}), 0);
        check("dut2 stop-high cycles", stop_high, 6);
        check("dut2 frame length", fd_at2 - first_low2 + 1, 33);
        tx_en2 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
